// File: rtl/clint_pkg.sv
// Shared constants and types for the CLINT register-access controller.
package clint_pkg;

    // Byte offsets of the CLINT register groups
    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    // Upper bound on HART_NUM; per-hart tables are padded to this size
    localparam int MAX_HARTS = 16;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE,
        WRESP,
        RRESP
    } state_t;

    // Register targeted by a decoded offset
    typedef enum logic [2:0] {
        MSIP,
        CMP_L,
        CMP_H,
        MT_L,
        MT_H,
        NONE
    } reg_kind_t;

endpackage

// File: rtl/clint_addr_dec.sv
// Combinational CLINT offset decoder: register kind, hart index and error flag.
module clint_addr_dec
    import clint_pkg::*;
#(
    parameter int HART_NUM = 1
) (
    input  logic [15:0] addr,
    output reg_kind_t   kind,
    output logic [3:0]  hart,
    output logic        err
);

    localparam logic [15:0] HART_LIMIT = 16'(HART_NUM);

    // Candidate hart indices for the two per-hart regions
    logic [15:0] msip_idx;
    logic [15:0] cmp_idx;

    assign msip_idx = (addr - MSIP_BASE) >> 2;
    assign cmp_idx  = (addr - MTIMECMP_BASE) >> 3;

    // Classify the offset; anything misaligned, unmapped or past the last hart is NONE
    always_comb begin
        kind = NONE;
        hart = 4'd0;
        if (addr[1:0] == 2'b00) begin
            if (addr < MTIMECMP_BASE) begin
                if (msip_idx < HART_LIMIT) begin
                    kind = MSIP;
                    hart = msip_idx[3:0];
                end
            end else if (addr == MTIME_LO) begin
                kind = MT_L;
            end else if (addr == MTIME_HI) begin
                kind = MT_H;
            end else if (addr < MTIME_LO) begin
                if (cmp_idx < HART_LIMIT) begin
                    kind = addr[2] ? CMP_H : CMP_L;
                    hart = cmp_idx[3:0];
                end
            end
        end
    end

    assign err = (kind == NONE);

endmodule

// File: rtl/clint_bus_ctrl.sv
// Round-robin write/read request arbiter and register decoder in front of clint_core.
module clint_bus_ctrl
    import clint_pkg::*;
#(
    parameter int HART_NUM = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [15:0]             wr_addr,
    input  logic [31:0]             wr_data,
    input  logic [3:0]              wr_strb,
    output logic                    wr_resp_valid,
    input  logic                    wr_resp_ready,
    output logic                    wr_resp_err,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [15:0]             rd_addr,
    output logic                    rd_resp_valid,
    input  logic                    rd_resp_ready,
    output logic [31:0]             rd_data,
    output logic                    rd_resp_err,
    output logic                    mtime_l_wen,
    output logic                    mtime_h_wen,
    output logic [HART_NUM-1:0]     mtimecmp_l_wen,
    output logic [HART_NUM-1:0]     mtimecmp_h_wen,
    output logic [HART_NUM-1:0]     msip_wen,
    output logic [31:0]             reg_wdata,
    input  logic [63:0]             mtime,
    input  logic [64*HART_NUM-1:0]  mtimecmp,
    input  logic [HART_NUM-1:0]     msip
);

    state_t      state_reg, state_next;
    logic        last_wr_reg;          // 1 = most recent grant went to the write channel
    logic        grant_wr, grant_rd;

    reg_kind_t   wr_kind, rd_kind;
    logic [3:0]  wr_hart, rd_hart;
    logic        wr_dec_err, rd_dec_err;
    logic        wr_err;

    logic [31:0] reg_wdata_reg;
    logic        wr_resp_err_reg;
    logic [31:0] rd_data_reg;
    logic        rd_resp_err_reg;
    logic [31:0] rd_value;

    logic [31:0] shadow_reg;
    logic        shadow_vld_reg;

    logic                mtime_l_wen_reg, mtime_h_wen_reg;
    logic [HART_NUM-1:0] cmp_l_wen_reg, cmp_h_wen_reg, msip_wen_reg;
    logic [HART_NUM-1:0] hart_sel;

    logic [31:0] cmp_lo_arr [MAX_HARTS];
    logic [31:0] cmp_hi_arr [MAX_HARTS];
    logic        msip_arr   [MAX_HARTS];

    clint_addr_dec #(.HART_NUM(HART_NUM)) u_wr_dec (
        .addr (wr_addr),
        .kind (wr_kind),
        .hart (wr_hart),
        .err  (wr_dec_err)
    );

    clint_addr_dec #(.HART_NUM(HART_NUM)) u_rd_dec (
        .addr (rd_addr),
        .kind (rd_kind),
        .hart (rd_hart),
        .err  (rd_dec_err)
    );

    // Partial-word writes are rejected; only full 32-bit stores reach the core
    assign wr_err = wr_dec_err || (wr_strb != 4'hF);

    // Per-hart views of the core registers, zero-padded so a 4-bit index always lands in range
    generate
        for (genvar gi = 0; gi < MAX_HARTS; gi++) begin : g_unpack
            if (gi < HART_NUM) begin : g_live
                assign cmp_lo_arr[gi] = mtimecmp[64*gi +: 32];
                assign cmp_hi_arr[gi] = mtimecmp[64*gi+32 +: 32];
                assign msip_arr[gi]   = msip[gi];
            end else begin : g_pad
                assign cmp_lo_arr[gi] = 32'd0;
                assign cmp_hi_arr[gi] = 32'd0;
                assign msip_arr[gi]   = 1'b0;
            end
        end
        for (genvar gi = 0; gi < HART_NUM; gi++) begin : g_sel
            assign hart_sel[gi] = (wr_hart == 4'(gi));
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and grant logic: round-robin between channels when both request
    always_comb begin
        state_next = state_reg;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rst) begin
                    if (wr_valid && (!rd_valid || !last_wr_reg)) begin
                        grant_wr   = 1'b1;
                        state_next = WRESP;
                    end else if (rd_valid) begin
                        grant_rd   = 1'b1;
                        state_next = RRESP;
                    end
                end
            end
            WRESP:   if (wr_resp_ready) state_next = IDLE;
            RRESP:   if (rd_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read mux; the high mtime half prefers the snapshot taken by the preceding low-half read
    always_comb begin
        rd_value = 32'd0;
        case (rd_kind)
            MSIP:    rd_value = {31'd0, msip_arr[rd_hart]};
            CMP_L:   rd_value = cmp_lo_arr[rd_hart];
            CMP_H:   rd_value = cmp_hi_arr[rd_hart];
            MT_L:    rd_value = mtime[31:0];
            MT_H:    rd_value = shadow_vld_reg ? shadow_reg : mtime[63:32];
            default: rd_value = 32'd0;
        endcase
    end

    // Capture write data/status and raise a single one-cycle write enable after an accepted write
    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_reg     <= 1'b0;
            reg_wdata_reg   <= 32'd0;
            wr_resp_err_reg <= 1'b0;
            mtime_l_wen_reg <= 1'b0;
            mtime_h_wen_reg <= 1'b0;
            cmp_l_wen_reg   <= '0;
            cmp_h_wen_reg   <= '0;
            msip_wen_reg    <= '0;
        end else begin
            mtime_l_wen_reg <= 1'b0;
            mtime_h_wen_reg <= 1'b0;
            cmp_l_wen_reg   <= '0;
            cmp_h_wen_reg   <= '0;
            msip_wen_reg    <= '0;
            if (grant_wr) begin
                last_wr_reg     <= 1'b1;
                reg_wdata_reg   <= wr_data;
                wr_resp_err_reg <= wr_err;
                if (!wr_err) begin
                    case (wr_kind)
                        MSIP:    msip_wen_reg    <= hart_sel;
                        CMP_L:   cmp_l_wen_reg   <= hart_sel;
                        CMP_H:   cmp_h_wen_reg   <= hart_sel;
                        MT_L:    mtime_l_wen_reg <= 1'b1;
                        MT_H:    mtime_h_wen_reg <= 1'b1;
                        default: ;
                    endcase
                end
            end else if (grant_rd) begin
                last_wr_reg <= 1'b0;
            end
        end
    end

    // Capture read data/status and maintain the mtime high-half snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg     <= 32'd0;
            rd_resp_err_reg <= 1'b0;
            shadow_reg      <= 32'd0;
            shadow_vld_reg  <= 1'b0;
        end else begin
            if (grant_rd) begin
                rd_resp_err_reg <= rd_dec_err;
                rd_data_reg     <= rd_dec_err ? 32'd0 : rd_value;
                if (rd_kind == MT_L) begin
                    shadow_reg     <= mtime[63:32];
                    shadow_vld_reg <= 1'b1;
                end else if (rd_kind == MT_H) begin
                    shadow_vld_reg <= 1'b0;
                end
            end
            // A software update of mtime invalidates any pending snapshot
            if (grant_wr && !wr_err && (wr_kind == MT_L || wr_kind == MT_H)) begin
                shadow_vld_reg <= 1'b0;
            end
        end
    end

    assign wr_ready       = grant_wr;
    assign rd_ready       = grant_rd;
    assign wr_resp_valid  = (state_reg == WRESP);
    assign rd_resp_valid  = (state_reg == RRESP);
    assign wr_resp_err    = wr_resp_err_reg;
    assign rd_resp_err    = rd_resp_err_reg;
    assign rd_data        = rd_data_reg;
    assign reg_wdata      = reg_wdata_reg;
    assign mtime_l_wen    = mtime_l_wen_reg;
    assign mtime_h_wen    = mtime_h_wen_reg;
    assign mtimecmp_l_wen = cmp_l_wen_reg;
    assign mtimecmp_h_wen = cmp_h_wen_reg;
    assign msip_wen       = msip_wen_reg;

endmodule

// File: tb/tb_clint_bus_ctrl.sv
// Randomized self-checking bench for clint_bus_ctrl (HART_NUM = 2) against a behavioural model.
module tb_clint_bus_ctrl;

    localparam int HN = 2;

    localparam int K_MSIP = 0;
    localparam int K_CL   = 1;
    localparam int K_CH   = 2;
    localparam int K_ML   = 3;
    localparam int K_MH   = 4;
    localparam int K_NONE = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid, wr_ready;
    logic [15:0]     wr_addr;
    logic [31:0]     wr_data;
    logic [3:0]      wr_strb;
    logic            wr_resp_valid, wr_resp_ready, wr_resp_err;
    logic            rd_valid, rd_ready;
    logic [15:0]     rd_addr;
    logic            rd_resp_valid, rd_resp_ready;
    logic [31:0]     rd_data;
    logic            rd_resp_err;
    logic            mtime_l_wen, mtime_h_wen;
    logic [HN-1:0]   mtimecmp_l_wen, mtimecmp_h_wen, msip_wen;
    logic [31:0]     reg_wdata;
    logic [63:0]     mtime;
    logic [64*HN-1:0] mtimecmp;
    logic [HN-1:0]   msip;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit          m_last_wr;
    bit          m_shadow_vld;
    logic [31:0] m_shadow;

    logic [15:0] addr_pool [16] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000,
                                    16'h4004, 16'h4008, 16'h400C, 16'h4010,
                                    16'hBFF8, 16'hBFFC, 16'hBFF8, 16'hBFFC,
                                    16'h4001, 16'h0002, 16'h8000, 16'hC000};

    clint_bus_ctrl #(.HART_NUM(HN)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_strb        (wr_strb),
        .wr_resp_valid  (wr_resp_valid),
        .wr_resp_ready  (wr_resp_ready),
        .wr_resp_err    (wr_resp_err),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_addr        (rd_addr),
        .rd_resp_valid  (rd_resp_valid),
        .rd_resp_ready  (rd_resp_ready),
        .rd_data        (rd_data),
        .rd_resp_err    (rd_resp_err),
        .mtime_l_wen    (mtime_l_wen),
        .mtime_h_wen    (mtime_h_wen),
        .mtimecmp_l_wen (mtimecmp_l_wen),
        .mtimecmp_h_wen (mtimecmp_h_wen),
        .msip_wen       (msip_wen),
        .reg_wdata      (reg_wdata),
        .mtime          (mtime),
        .mtimecmp       (mtimecmp),
        .msip           (msip)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Map an offset to a register by enumerating every mapped address
    function automatic void ref_decode(input logic [15:0] a, output int kind, output int h);
        kind = K_NONE;
        h    = 0;
        for (int i = 0; i < HN; i++) begin
            if (a == 16'(4 * i))            begin kind = K_MSIP; h = i; end
            if (a == 16'(32'h4000 + 8 * i)) begin kind = K_CL;   h = i; end
            if (a == 16'(32'h4004 + 8 * i)) begin kind = K_CH;   h = i; end
        end
        if (a == 16'hBFF8) kind = K_ML;
        if (a == 16'hBFFC) kind = K_MH;
    endfunction

    function automatic logic [7:0] wen_vec();
        return {mtime_l_wen, mtime_h_wen, mtimecmp_l_wen, mtimecmp_h_wen, msip_wen};
    endfunction

    task automatic chk_resp(input bit gw, input bit gr, input bit werr, input bit rerr,
                            input logic [31:0] exp_rd, input logic [7:0] exp_wen);
        chk("busy_wr_ready", 64'(wr_ready), 64'(0));
        chk("busy_rd_ready", 64'(rd_ready), 64'(0));
        chk("wr_resp_valid", 64'(wr_resp_valid), 64'(gw));
        chk("rd_resp_valid", 64'(rd_resp_valid), 64'(gr));
        chk("wen", 64'(wen_vec()), 64'(exp_wen));
        if (gw) chk("wr_resp_err", 64'(wr_resp_err), 64'(werr));
        if (gr) begin
            chk("rd_resp_err", 64'(rd_resp_err), 64'(rerr));
            chk("rd_data", 64'(rd_data), 64'(exp_rd));
        end
    endtask

    // One request cycle, response with `hold` stalled cycles, then the handshake
    task automatic do_txn(input bit wv, input bit rv, input logic [15:0] wa, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [15:0] ra, input int hold,
                          output logic [31:0] rd_got);
        bit gw, gr, werr, rerr;
        int wk, wh, rk, rh;
        logic [31:0] exp_rd;
        logic [7:0]  exp_wen;
        rd_got        = 32'd0;
        wr_valid      = wv;
        rd_valid      = rv;
        wr_addr       = wa;
        wr_data       = wd;
        wr_strb       = ws;
        rd_addr       = ra;
        wr_resp_ready = 1'b0;
        rd_resp_ready = 1'b0;
        #1;
        gw = wv && (!rv || !m_last_wr);
        gr = rv && !gw;
        chk("wr_ready", 64'(wr_ready), 64'(gw));
        chk("rd_ready", 64'(rd_ready), 64'(gr));
        ref_decode(wa, wk, wh);
        ref_decode(ra, rk, rh);
        werr    = (wk == K_NONE) || (ws != 4'hF);
        rerr    = (rk == K_NONE);
        exp_wen = 8'd0;
        exp_rd  = 32'd0;
        if (gw) begin
            m_last_wr = 1'b1;
            if (!werr) begin
                case (wk)
                    K_MSIP: exp_wen[wh]     = 1'b1;
                    K_CH:   exp_wen[2 + wh] = 1'b1;
                    K_CL:   exp_wen[4 + wh] = 1'b1;
                    K_MH:   exp_wen[6]      = 1'b1;
                    K_ML:   exp_wen[7]      = 1'b1;
                    default: ;
                endcase
                if (wk == K_ML || wk == K_MH) m_shadow_vld = 1'b0;
            end
        end
        if (gr) begin
            m_last_wr = 1'b0;
            case (rk)
                K_MSIP: exp_rd = {31'd0, msip[rh]};
                K_CL:   exp_rd = mtimecmp[64*rh +: 32];
                K_CH:   exp_rd = mtimecmp[64*rh+32 +: 32];
                K_ML: begin
                    exp_rd       = mtime[31:0];
                    m_shadow     = mtime[63:32];
                    m_shadow_vld = 1'b1;
                end
                K_MH: begin
                    exp_rd       = m_shadow_vld ? m_shadow : mtime[63:32];
                    m_shadow_vld = 1'b0;
                end
                default: exp_rd = 32'd0;
            endcase
        end
        @(posedge clk); #1;
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        #1;
        chk_resp(gw, gr, werr, rerr, exp_rd, exp_wen);
        if (gw) chk("reg_wdata", 64'(reg_wdata), 64'(wd));
        rd_got = rd_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            chk_resp(gw, gr, werr, rerr, exp_rd, 8'd0);
        end
        wr_valid      = 1'b0;
        rd_valid      = 1'b0;
        wr_resp_ready = gw;
        rd_resp_ready = gr;
        @(posedge clk); #1;
        wr_resp_ready = 1'b0;
        rd_resp_ready = 1'b0;
        #1;
        chk("done_wr_resp_valid", 64'(wr_resp_valid), 64'(0));
        chk("done_rd_resp_valid", 64'(rd_resp_valid), 64'(0));
        chk("done_wen", 64'(wen_vec()), 64'(0));
    endtask

    task automatic model_reset();
        m_last_wr    = 1'b0;
        m_shadow_vld = 1'b0;
        m_shadow     = 32'd0;
    endtask

    initial begin
        logic [31:0] got;
        bit          wv, rv;
        logic [3:0]  ws;

        rst           = 1'b1;
        wr_valid      = 1'b1;
        rd_valid      = 1'b1;
        wr_addr       = 16'h4000;
        wr_data       = 32'hDEAD_BEEF;
        wr_strb       = 4'hF;
        rd_addr       = 16'hBFF8;
        wr_resp_ready = 1'b0;
        rd_resp_ready = 1'b0;
        mtime         = 64'h0000_0001_FFFF_FFFF;
        mtimecmp      = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        msip          = 2'b10;
        model_reset();

        // Reset state, with both requests pending to show readies stay low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_rd_ready", 64'(rd_ready), 64'(0));
        chk("rst_wen", 64'(wen_vec()), 64'(0));
        chk("rst_reg_wdata", 64'(reg_wdata), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_wr_resp_valid", 64'(wr_resp_valid), 64'(0));
        chk("rst_rd_resp_valid", 64'(rd_resp_valid), 64'(0));
        chk("rst_wr_resp_err", 64'(wr_resp_err), 64'(0));
        chk("rst_rd_resp_err", 64'(rd_resp_err), 64'(0));
        rst      = 1'b0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;

        // Both channels valid for four grants: W, R, W, R
        for (int i = 0; i < 4; i++) begin
            chk("alt_grant_is_write", 64'(!m_last_wr), 64'(i % 2 == 0));
            do_txn(1'b1, 1'b1, 16'h4004, 32'(i), 4'hF, 16'h0004, 0, got);
        end

        // Write mtimecmp[1] low with full strobes, then a partial write that must be rejected
        do_txn(1'b1, 1'b0, 16'h4008, 32'h10, 4'hF, 16'h0000, 0, got);
        do_txn(1'b1, 1'b0, 16'h0004, 32'h1, 4'h3, 16'h0000, 1, got);

        // Torn-read protection: high half comes from the snapshot, then from live mtime
        mtime = 64'h0000_0001_FFFF_FFFF;
        do_txn(1'b0, 1'b1, 16'h0000, 32'h0, 4'hF, 16'hBFF8, 0, got);
        chk("plan_mtime_lo", 64'(got), 64'(32'hFFFF_FFFF));
        repeat (5) @(posedge clk);
        #1;
        mtime = 64'h0000_0002_0000_0000;
        do_txn(1'b0, 1'b1, 16'h0000, 32'h0, 4'hF, 16'hBFFC, 0, got);
        chk("plan_mtime_hi_shadow", 64'(got), 64'(32'h1));
        do_txn(1'b0, 1'b1, 16'h0000, 32'h0, 4'hF, 16'hBFFC, 0, got);
        chk("plan_mtime_hi_live", 64'(got), 64'(32'h2));

        // Out-of-range hart read, response stalled for three cycles
        do_txn(1'b0, 1'b1, 16'h0000, 32'h0, 4'hF, 16'h4010, 3, got);
        chk("plan_err_rd_data", 64'(got), 64'(0));

        // Reset while a write response is pending
        wr_valid = 1'b1;
        wr_addr  = 16'h4000;
        wr_data  = 32'hCAFE_0001;
        wr_strb  = 4'hF;
        #1;
        chk("pre_rst_wr_ready", 64'(wr_ready), 64'(1));
        @(posedge clk); #1;
        chk("pre_rst_wr_resp_valid", 64'(wr_resp_valid), 64'(1));
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 16'h0000;
        #1;
        chk("in_rst_rd_ready", 64'(rd_ready), 64'(0));
        @(posedge clk); #1;
        chk("post_rst_wr_resp_valid", 64'(wr_resp_valid), 64'(0));
        chk("post_rst_wen", 64'(wen_vec()), 64'(0));
        chk("post_rst_rd_ready", 64'(rd_ready), 64'(0));
        rst = 1'b0;
        model_reset();
        do_txn(1'b1, 1'b1, 16'h0000, 32'h1, 4'hF, 16'h0004, 0, got);
        do_txn(1'b0, 1'b1, 16'h0000, 32'h0, 4'hF, 16'h0004, 0, got);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            if (!wv && !rv) rv = 1'b1;
            ws       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            mtime    = {$urandom, $urandom};
            mtimecmp = {$urandom, $urandom, $urandom, $urandom};
            msip     = 2'($urandom);
            do_txn(wv, rv, addr_pool[$urandom_range(0, 15)], $urandom, ws,
                   addr_pool[$urandom_range(0, 15)], $urandom_range(0, 2), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_bus_ctrl.md
Name: clint_bus_ctrl

Overview:
Register-access controller in front of clint_core.
- Accepts word reads and writes from two independent request channels, a write channel and a read channel.
- Arbitrates the two channels round-robin onto the single core register file.
- Decodes the standard CLINT map into the core's per-register write enables and reg_wdata.
- Returns read data with a torn-read-safe mtime snapshot.

Parameters:
HART_NUM, 1, number of harts; sets the widths of msip, mtimecmp and the write enables (1..16).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  write request accepted this cycle.
- wr_addr  input  16  byte offset in the CLINT space.
- wr_data  input  32  write data.
- wr_strb  input  4  byte strobes.
- wr_resp_valid  output  1  write response valid.
- wr_resp_ready  input  1  write response taken.
- wr_resp_err  output  1  1 = request rejected.
- rd_valid  input  1  read request valid.
- rd_ready  output  1  read request accepted.
- rd_addr  input  16  byte offset.
- rd_resp_valid  output  1  read response valid.
- rd_resp_ready  input  1  read response taken.
- rd_data  output  32  read data (0 on error).
- rd_resp_err  output  1  1 = request rejected.
- mtime_l_wen, mtime_h_wen  output  1 each  core write enables.
- mtimecmp_l_wen, mtimecmp_h_wen, msip_wen  output  HART_NUM each  core write enables.
- reg_wdata  output  32  core write data.
- mtime  input  64  from core.
- mtimecmp  input  64*HART_NUM  from core.
- msip  input  HART_NUM  from core.

Behaviour:
- Address map (word-aligned):
  - msip[h] at 0x0000+4h.
  - mtimecmp[h] low/high at 0x4000+8h / 0x4004+8h.
  - mtime low/high at 0xBFF8 / 0xBFFC.
- Error conditions:
  - addr[1:0] != 0.
  - Unmapped offset.
  - h >= HART_NUM.
  - For writes only: wr_strb != 4'hF.
- FSM states: IDLE, WRESP, RRESP.
- IDLE:
  - Only one request valid: grant it.
  - Both valid: grant the channel not granted last; after reset, write wins first.
  - The grant asserts the matching ready combinationally, in the same cycle.
  - Write grant goes to WRESP; read grant goes to RRESP.
- Write, accept cycle T:
  - reg_wdata is registered with wr_data at T.
  - Exactly one decoded wen pulses high for one cycle at T+1, only if no error.
  - wr_resp_valid rises at T+1 with wr_resp_err.
- Read, accept cycle T:
  - rd_data and rd_resp_err are registered at T.
  - rd_resp_valid rises at T+1.
  - msip reads return {31'b0, msip[h]}.
  - mtimecmp reads return the live halves.
- WRESP and RRESP:
  - Hold valid, err and data stable until the resp_ready handshake, then return to IDLE.
  - No new request is accepted while in a response state.
  - Minimum 2 cycles per transaction; zero-wait back-to-back throughput is one request per 2 cycles.
- mtime snapshot:
  - A read of 0xBFF8 returns mtime[31:0] and, in the same cycle, latches mtime[63:32] into the shadow and sets shadow_vld.
  - A read of 0xBFFC returns the shadow if shadow_vld, then clears it; otherwise it returns live mtime[63:32].
  - Any accepted non-error write to 0xBFF8 or 0xBFFC clears shadow_vld.
- Reset values, on the cycle after rst is sampled high:
  - All wens 0, reg_wdata 0, rd_data 0.
  - Resp valids 0, err 0, ready 0.
  - State IDLE, last grant = read (so write wins next), shadow_vld 0, shadow 0.
- Reset mid-transaction abandons any pending response; no wen is issued for an abandoned write beyond the cycle it was already driven.
- While rst is high, readies stay 0.

Decomposition:
- Shared package clint_pkg holds:
  - Offset constants: MSIP_BASE 0x0000, MTIMECMP_BASE 0x4000, MTIME_LO 0xBFF8, MTIME_HI 0xBFFC.
  - FSM state encoding.
  - Register-kind enum: MSIP, CMP_L, CMP_H, MT_L, MT_H, NONE.
- One combinational sub-module, clint_addr_dec, is instanced once per channel.
  - Inputs: addr. Outputs: kind, hart index, err.

Test Plan:
- HART_NUM=2: write 0x4008 data 0x10 strb F → at T+1 mtimecmp_l_wen=2'b10 for 1 cycle, reg_wdata=0x10, wr_resp_err=0.
- Write 0x0004 strb 4'h3 → no wen pulses; wr_resp_err=1.
- Write and read both valid every cycle for 4 grants → grants alternate W,R,W,R, starting with W after reset.
- mtime=0x1_FFFF_FFFF: read 0xBFF8 → 0xFFFF_FFFF; wait 5 cycles; read 0xBFFC → 0x1 (shadow, not live 0x2); a second 0xBFFC read returns live.
- Read 0x4010 with HART_NUM=2 → rd_resp_err=1, rd_data=0; hold rd_resp_ready=0 for 3 cycles → response stays stable.
- Assert rst while in WRESP → next cycle wr_resp_valid=0, state IDLE, no wen; a pending read is granted first afterward only if no write is valid.
